// File: rtl/nt_bist_pkg.sv
// Shared types and constants for the Nt-node subcircuit BIST driver and its MISR.
package nt_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    FLUSH,
    COMPARE,
    DONE
  } bist_state_t;

  localparam int LFSR_W = 8;
  localparam int SIG_W  = 16;
  localparam int CNT_W  = 16;
  localparam int LAT_W  = 4;

  localparam logic [SIG_W-1:0]  MISR_POLY = 16'h1021;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  // Fibonacci step: feedback is the parity of the tapped bits, shifted in at the LSB.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/nt_bist_misr.sv
// 16-bit serial-input MISR with enable and synchronous clear; shared with the multi-output harness.
module nt_bist_misr
  import nt_bist_pkg::*;
(
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  always_ff @(posedge gclk) begin
    if (!grst_n)
      sig <= '0;
    else if (clr)
      sig <= '0;
    else if (en)
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0) ^ {{(SIG_W-1){1'b0}}, din};
  end

endmodule

// File: rtl/nt_subckt_bist_driver.sv
// BIST driver: LFSR stimulus, latency-aligned MISR compaction, golden compare.
// Optional NT_BIST_DUT_RESET_EN adds dut_rst_n to hold the subcircuit in reset outside a run.
module nt_subckt_bist_driver
  import nt_bist_pkg::*;
#(
  parameter int               STIM_W       = 6,
  parameter int               NUM_PATTERNS = 1000,
  parameter int               DUT_LAT      = 2,
  parameter logic [LFSR_W-1:0] SEED        = 8'h01,
  parameter logic [SIG_W-1:0]  GOLDEN      = 16'h0000
)(
  input  logic              I1470_clk,
  input  logic              I1477_rst,
  input  logic              start,
  output logic [STIM_W-1:0] stim,
  input  logic              resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
`ifdef NT_BIST_DUT_RESET_EN
  output logic              dut_rst_n,
`endif
  output logic [SIG_W-1:0]  signature
);

  localparam logic [CNT_W-1:0] NP_LAST = CNT_W'(NUM_PATTERNS - 1);
  localparam logic [LAT_W-1:0] LAT     = LAT_W'(DUT_LAT);

  bist_state_t       state, state_n;
  logic [LFSR_W-1:0] lfsr;
  logic [CNT_W-1:0]  apply_cnt;
  logic [CNT_W-1:0]  cap_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              pass_q;
  logic [SIG_W-1:0]  misr;

  logic running, accept, cap_en;

  // lat_cnt saturates at DUT_LAT, so it reads min(run cycle, DUT_LAT); capture opens once it saturates.
  always_comb begin
    state_n = state;
    running = (state == APPLY) || (state == FLUSH);
    accept  = start && ((state == IDLE) || (state == DONE));
    cap_en  = running && (lat_cnt == LAT);
    busy    = running || (state == COMPARE);
    done    = (state == DONE);
    case (state)
      IDLE, DONE: if (start) state_n = APPLY;
      APPLY:      if (apply_cnt == NP_LAST) state_n = (DUT_LAT == 0) ? COMPARE : FLUSH;
      FLUSH:      if (cap_en && (cap_cnt == NP_LAST)) state_n = COMPARE;
      COMPARE:    state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge I1470_clk) begin
    if (!I1477_rst) begin
      state     <= IDLE;
      lfsr      <= SEED;
      apply_cnt <= '0;
      cap_cnt   <= '0;
      lat_cnt   <= '0;
      pass_q    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        lfsr      <= SEED;
        apply_cnt <= '0;
        cap_cnt   <= '0;
        lat_cnt   <= '0;
        pass_q    <= 1'b0;
      end else begin
        if (running)                  lfsr      <= lfsr_step(lfsr);
        if (state == APPLY)           apply_cnt <= apply_cnt + CNT_W'(1);
        if (running && lat_cnt != LAT) lat_cnt  <= lat_cnt + LAT_W'(1);
        if (cap_en)                   cap_cnt   <= cap_cnt + CNT_W'(1);
        if (state == COMPARE)         pass_q    <= (misr == GOLDEN);
      end
    end
  end

  nt_bist_misr u_misr (
    .gclk   (I1470_clk),
    .grst_n (I1477_rst),
    .clr    (accept),
    .en     (cap_en),
    .din    (resp),
    .sig    (misr)
  );

  assign stim      = lfsr[STIM_W-1:0];
  assign pass      = pass_q;
  assign signature = misr;

`ifdef NT_BIST_DUT_RESET_EN
  assign dut_rst_n = busy;
`endif

endmodule

// File: tb/tb_nt_subckt_bist_driver.sv
// Bench: four driver configurations on one clock; directed runs plus a random-response run checked
// against a cycle-window signature model.
module tb_nt_subckt_bist_driver;

  localparam int NP_R = 40;
  localparam int L_R  = 3;
  localparam int DONE_R = NP_R + L_R + 1;
  localparam int RUN_CYC = 50;

  logic clk = 1'b0;
  logic rst_n, start, resp_r;
  always #5 clk = ~clk;

  logic [5:0]  stim_a, stim_z, stim_b;
  logic [7:0]  stim_r;
  logic        busy_a, busy_z, busy_b, busy_r;
  logic        done_a, done_z, done_b, done_r;
  logic        pass_a, pass_z, pass_b, pass_r;
  logic [15:0] sig_a, sig_z, sig_b, sig_r;
`ifdef NT_BIST_DUT_RESET_EN
  logic dr_a, dr_z, dr_b, dr_r;
`endif

  int ncmp = 0;
  int nfail = 0;
  bit rk [0:RUN_CYC-1];

  nt_subckt_bist_driver #(.STIM_W(6), .NUM_PATTERNS(2), .DUT_LAT(2), .SEED(8'h01), .GOLDEN(16'h0003)) u_a (
    .I1470_clk(clk), .I1477_rst(rst_n), .start(start), .stim(stim_a), .resp(1'b1),
    .busy(busy_a), .done(done_a), .pass(pass_a),
`ifdef NT_BIST_DUT_RESET_EN
    .dut_rst_n(dr_a),
`endif
    .signature(sig_a));

  nt_subckt_bist_driver #(.STIM_W(6), .NUM_PATTERNS(2), .DUT_LAT(2), .SEED(8'h01), .GOLDEN(16'h0000)) u_z (
    .I1470_clk(clk), .I1477_rst(rst_n), .start(start), .stim(stim_z), .resp(1'b1),
    .busy(busy_z), .done(done_z), .pass(pass_z),
`ifdef NT_BIST_DUT_RESET_EN
    .dut_rst_n(dr_z),
`endif
    .signature(sig_z));

  nt_subckt_bist_driver #(.STIM_W(6), .NUM_PATTERNS(1), .DUT_LAT(0), .SEED(8'h01), .GOLDEN(16'h0001)) u_b (
    .I1470_clk(clk), .I1477_rst(rst_n), .start(start), .stim(stim_b), .resp(1'b1),
    .busy(busy_b), .done(done_b), .pass(pass_b),
`ifdef NT_BIST_DUT_RESET_EN
    .dut_rst_n(dr_b),
`endif
    .signature(sig_b));

  nt_subckt_bist_driver #(.STIM_W(8), .NUM_PATTERNS(NP_R), .DUT_LAT(L_R), .SEED(8'hA7), .GOLDEN(16'h0000)) u_r (
    .I1470_clk(clk), .I1477_rst(rst_n), .start(start), .stim(stim_r), .resp(resp_r),
    .busy(busy_r), .done(done_r), .pass(pass_r),
`ifdef NT_BIST_DUT_RESET_EN
    .dut_rst_n(dr_r),
`endif
    .signature(sig_r));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_adv(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Signature = CRC-style fold of the responses seen in run cycles [lat, lat+np).
  function automatic logic [15:0] model_sig(input int lat, input int np);
    logic [15:0] m = '0;
    logic        c;
    for (int k = lat; k < lat + np; k++) begin
      c = m[15];
      m = {m[14:0], 1'b0};
      if (c) m = m ^ 16'h1021;
      m[0] = m[0] ^ rk[k];
    end
    return m;
  endfunction

  task automatic run(input bit replay, input string tag);
    logic [7:0]  la = 8'h01;
    logic [7:0]  lr = 8'hA7;
    logic [15:0] exp_r;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < RUN_CYC; k++) begin
      if (k < 5) chk({tag, " stim_a"}, stim_a, la[5:0]);
      if (k < DONE_R) chk({tag, " stim_r"}, stim_r, lr);
      chk({tag, " done_a"}, done_a, k >= 5);
      chk({tag, " pass_a"}, pass_a, k >= 5);
      chk({tag, " done_b"}, done_b, k >= 2);
      chk({tag, " done_r"}, done_r, k >= DONE_R);
      chk({tag, " busy_r"}, busy_r, k < DONE_R);
`ifdef NT_BIST_DUT_RESET_EN
      chk({tag, " dut_rst_n_r"}, dr_r, k < DONE_R);
      chk({tag, " dut_rst_n_b"}, dr_b, k < 2);
`endif
      if (k == 5) begin
        chk({tag, " sig_a"}, sig_a, 16'h0003);
        chk({tag, " sig_z"}, sig_z, 16'h0003);
        chk({tag, " pass_z"}, pass_z, 1'b0);
        chk({tag, " done_z"}, done_z, 1'b1);
      end
      if (k == 2) begin
        chk({tag, " sig_b"}, sig_b, 16'h0001);
        chk({tag, " pass_b"}, pass_b, 1'b1);
      end
      la = lfsr_adv(la);
      if (k < NP_R + L_R) lr = lfsr_adv(lr);
      if (!replay) rk[k] = 1'($urandom_range(0, 1));
      resp_r = rk[k];
      start  = (k == 1);  // second start mid-run must be ignored
      @(posedge clk); #1;
    end
    start = 1'b0;
    exp_r = model_sig(L_R, NP_R);
    chk({tag, " sig_r"}, sig_r, exp_r);
    chk({tag, " pass_r"}, pass_r, exp_r == 16'h0000);
    chk({tag, " sig_a hold"}, sig_a, 16'h0003);
    chk({tag, " pass_a hold"}, pass_a, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; resp_r = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst stim_a", stim_a, 6'h01);
    chk("rst stim_r", stim_r, 8'hA7);
    chk("rst busy_a", busy_a, 1'b0);
    chk("rst done_a", done_a, 1'b0);
    chk("rst pass_a", pass_a, 1'b0);
    chk("rst sig_a", sig_a, 16'h0000);
    chk("rst sig_r", sig_r, 16'h0000);
`ifdef NT_BIST_DUT_RESET_EN
    chk("rst dut_rst_n", dr_a, 1'b0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle busy_r", busy_r, 1'b0);
    chk("idle stim_a", stim_a, 6'h01);

    run(1'b0, "run1");
    run(1'b1, "rerun");

    // Reset in run cycle 10 aborts the run completely.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrun busy_r", busy_r, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort stim_a", stim_a, 6'h01);
    chk("abort sig_a", sig_a, 16'h0000);
    chk("abort busy_a", busy_a, 1'b0);
    chk("abort busy_r", busy_r, 1'b0);
    chk("abort sig_r", sig_r, 16'h0000);
    chk("abort stim_r", stim_r, 8'hA7);
    chk("abort done_r", done_r, 1'b0);
`ifdef NT_BIST_DUT_RESET_EN
    chk("abort dut_rst_n", dr_r, 1'b0);
`endif
    @(posedge clk); #1;
    chk("post-abort idle", busy_r, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
